// File: rtl/uart_receiver.sv
// ==== uart_receiver: oversampling 8N1 UART receiver with holding register and status flags (rev 1.0)
// ==== Optional even-parity stage enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
`default_nettype none

module uart_receiver #(
  parameter int OVS       = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 bclkx8,
  input  logic                 rxd,
  input  logic                 rdrf_clr,
  output logic [DATA_BITS-1:0] rdbus,
  output logic                 rdrf,
  output logic                 fe,
  output logic                 oe,
  output logic                 pe
);

  localparam int CT1W = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [CT1W-1:0] C_HALF    = CT1W'(OVS / 2 - 1);
  localparam logic [CT1W-1:0] C_LAST    = CT1W'(OVS - 1);
  localparam logic [3:0]      C_LASTBIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CT1W-1:0]        ct1_q, ct1_d;
  logic [3:0]             ct2_q, ct2_d;
  logic [DATA_BITS-1:0]   rsr_q, rsr_d;
  logic                   bclk_q;
  logic [DATA_BITS-1:0]   rdbus_q, rdbus_d;
  logic                   rdrf_q, rdrf_d;
  logic                   fe_q, fe_d;
  logic                   oe_q, oe_d;
  logic                   tick;
  logic                   done;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;
`endif

  assign tick = bclkx8 & ~bclk_q;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ct1_q   <= '0;
      ct2_q   <= '0;
      rsr_q   <= '0;
      bclk_q  <= 1'b0;
      rdbus_q <= '0;
      rdrf_q  <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ct1_q   <= ct1_d;
      ct2_q   <= ct2_d;
      rsr_q   <= rsr_d;
      bclk_q  <= bclkx8;
      rdbus_q <= rdbus_d;
      rdrf_q  <= rdrf_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ct1_d   = ct1_q;
    ct2_d   = ct2_q;
    rsr_d   = rsr_q;
    rdbus_d = rdbus_q;
    rdrf_d  = rdrf_q;
    fe_d    = fe_q;
    oe_d    = oe_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd) begin
            state_d = S_START;
            ct1_d   = '0;
          end
        end
        S_START: begin
          // Mid start bit: a high line here was a glitch, not a frame.
          if (ct1_q == C_HALF) begin
            if (!rxd) begin
              state_d = S_DATA;
              ct1_d   = '0;
              ct2_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            ct1_d = ct1_q + 1'b1;
          end
        end
        S_DATA: begin
          if (ct1_q == C_LAST) begin
            rsr_d = {rxd, rsr_q[DATA_BITS-1:1]};
            ct1_d = '0;
            ct2_d = ct2_q + 4'd1;
            if (ct2_q == C_LASTBIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            ct1_d = ct1_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (ct1_q == C_LAST) begin
            par_d   = rxd;
            ct1_d   = '0;
            state_d = S_STOP;
          end else begin
            ct1_d = ct1_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (ct1_q == C_LAST) begin
            done    = 1'b1;
            ct1_d   = '0;
            state_d = S_IDLE;
          end else begin
            ct1_d = ct1_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (rdrf_clr) begin
      rdrf_d = 1'b0;
      oe_d   = 1'b0;
    end

    // Frame completion takes priority over a coincident host clear.
    if (done) begin
      rdbus_d = rsr_q;
      rdrf_d  = 1'b1;
      fe_d    = ~rxd;
      oe_d    = rdrf_q & ~rdrf_clr;
`ifdef UART_RX_PARITY_EN
      pe_d    = (^rsr_q) ^ par_q;
`endif
    end
  end

  assign rdbus = rdbus_q;
  assign rdrf  = rdrf_q;
  assign fe    = fe_q;
  assign oe    = oe_q;
`ifdef UART_RX_PARITY_EN
  assign pe    = pe_q;
`else
  assign pe    = 1'b0;
`endif

endmodule

`default_nettype wire
